// File: rtl/sysid_reader.sv
// ============================================================================
// Module   : sysid_reader
// Brief    : Avalon-MM master that reads the two-word system-ID slave
//            (ID, timestamp), compares both words against expected values and
//            reports match / mismatch / timeout status.
//            Optional build macro SYSID_READER_PERIODIC_EN adds a periodic
//            re-check driven by an idle-time counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'd933161164,
    parameter logic [31:0] EXPECTED_TS    = 32'd1310235670,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_READER_PERIODIC_EN
    ,
    parameter int unsigned RECHECK_PERIOD = 50_000_000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [7:0] c_timeout_limit = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_auto;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [7:0]  r_tcnt;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_idle;
    logic        w_periodic;
    logic        w_go;
    logic        w_active;
    logic        w_req;
    logic        w_accept;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic [7:0]  w_tcnt_inc;
    logic        w_abort;

    // The done cycle still counts as busy, so a start there is ignored too.
    assign w_idle     = (r_state == IDLE) && !r_done;
    assign w_go       = w_idle && (start || r_auto || w_periodic);
    assign w_req      = (r_state == REQ_ID) || (r_state == REQ_TS);
    assign w_active   = w_req || (r_state == WAIT_ID) || (r_state == WAIT_TS);
    assign w_accept   = w_req && !avm_waitrequest;
    assign w_tcnt_inc = r_tcnt + 8'd1;

    // Data accepted together with the command (zero-latency slave) counts.
    assign w_cap_id = avm_readdatavalid &&
                      (((r_state == REQ_ID) && w_accept) || (r_state == WAIT_ID));
    assign w_cap_ts = avm_readdatavalid &&
                      (((r_state == REQ_TS) && w_accept) || (r_state == WAIT_TS));

    // Data arriving on the last allowed cycle still wins over the abort.
    assign w_abort  = w_active && (w_tcnt_inc == c_timeout_limit) && !w_cap_id && !w_cap_ts;

`ifdef SYSID_READER_PERIODIC_EN
    localparam logic [31:0] c_period_last = 32'(RECHECK_PERIOD - 1);

    logic [31:0] r_period_cnt;

    assign w_periodic = w_idle && (r_period_cnt == c_period_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_cnt <= 32'd0;
        end else if (!w_idle || start || w_periodic) begin
            r_period_cnt <= 32'd0;
        end else begin
            r_period_cnt <= r_period_cnt + 32'd1;
        end
    end
`else
    assign w_periodic = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        avm_read     = 1'b0;
        avm_address  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) w_state_next = REQ_ID;
            end
            REQ_ID: begin
                avm_read = 1'b1;
                if (w_cap_id)      w_state_next = REQ_TS;
                else if (w_abort)  w_state_next = IDLE;
                else if (w_accept) w_state_next = WAIT_ID;
            end
            WAIT_ID: begin
                if (w_cap_id)     w_state_next = REQ_TS;
                else if (w_abort) w_state_next = IDLE;
            end
            REQ_TS: begin
                avm_read    = 1'b1;
                avm_address = 1'b1;
                if (w_cap_ts)      w_state_next = FINISH;
                else if (w_abort)  w_state_next = IDLE;
                else if (w_accept) w_state_next = WAIT_TS;
            end
            WAIT_TS: begin
                if (w_cap_ts)     w_state_next = FINISH;
                else if (w_abort) w_state_next = IDLE;
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_auto     <= AUTO_START;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_tcnt     <= 8'd0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
        end else begin
            r_done <= 1'b0;

            if (w_go) begin
                r_auto    <= 1'b0;
                r_id_ok   <= 1'b0;
                r_ts_ok   <= 1'b0;
                r_timeout <= 1'b0;
                r_tcnt    <= 8'd0;
            end else if (w_cap_id || w_cap_ts) begin
                r_tcnt <= 8'd0;
            end else if (w_active) begin
                r_tcnt <= w_tcnt_inc;
            end

            if (w_cap_id) r_id_value <= avm_readdata;
            if (w_cap_ts) r_ts_value <= avm_readdata;

            if (w_abort) begin
                r_timeout <= 1'b1;
                r_id_ok   <= 1'b0;
                r_ts_ok   <= 1'b0;
                r_done    <= 1'b1;
            end

            if (r_state == FINISH) begin
                r_id_ok <= (r_id_value == EXPECTED_ID);
                r_ts_ok <= (r_ts_value == EXPECTED_TS);
                r_done  <= 1'b1;
            end
        end
    end

    assign busy     = (r_state != IDLE) || r_done;
    assign done     = r_done;
    assign id_ok    = r_id_ok;
    assign ts_ok    = r_ts_ok;
    assign timeout  = r_timeout;
    assign id_value = r_id_value;
    assign ts_value = r_ts_value;

endmodule

`default_nettype wire
